// File: rtl/fib_seq_pkg.sv
// Shared mode encodings and FSM states for the generalised Fibonacci generator.
package fib_seq_pkg;

   localparam logic [1:0] MODE_WRAP   = 2'b00;
   localparam logic [1:0] MODE_STOP   = 2'b01;
   localparam logic [1:0] MODE_BOUNCE = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_UP   = 2'b01,
      ST_DOWN = 2'b10,
      ST_DONE = 2'b11
   } state_e;

   // Encoding 11 behaves as WRAP; folding it at latch time keeps the FSM decode simple.
   function automatic logic [1:0] norm_mode(input logic [1:0] m);
      return (m == 2'b11) ? MODE_WRAP : m;
   endfunction

endpackage

// File: rtl/fib_step.sv
// One sequence step: forward (a,b)->(b,a+b) or backward (a,b)->(b-a,a), plus limit overflow flag.
module fib_step
   import fib_seq_pkg::*;
#(
   parameter int unsigned      WIDTH = 20,
   parameter logic [WIDTH-1:0] LIMIT = '1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             dir,
   output logic [WIDTH-1:0] next_a,
   output logic [WIDTH-1:0] next_b,
   output logic             ovf
);

   logic [WIDTH:0] sum;

   // Overflow depends only on a,b so the caller may derive dir from it without a loop.
   assign sum    = {1'b0, a} + {1'b0, b};
   assign ovf    = (sum > {1'b0, LIMIT});
   assign next_a = dir ? (b - a) : b;
   assign next_b = dir ? a : sum[WIDTH-1:0];

endmodule

// File: rtl/fib_seq_gen.sv
// Generalised Fibonacci generator with WRAP/STOP/BOUNCE modes and valid/ready output.
// Optional term index output enabled by defining FIB_SEQ_IDX_EN.
module fib_seq_gen
   import fib_seq_pkg::*;
#(
   parameter int unsigned      WIDTH = 20,
   parameter logic [WIDTH-1:0] SEED0 = '0,
   parameter logic [WIDTH-1:0] SEED1 = WIDTH'(1),
   parameter logic [WIDTH-1:0] LIMIT = '1,
   parameter int unsigned      IDX_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] fn,
   output logic             done
`ifdef FIB_SEQ_IDX_EN
   ,
   output logic [IDX_W-1:0] idx
`endif
);

   state_e           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;
`ifdef FIB_SEQ_IDX_EN
   logic [IDX_W-1:0] idx_q, idx_d;
`else
   logic [31:0]      unused_idx_w;
   assign unused_idx_w = IDX_W;
`endif

   logic             seed_hit_c;
   logic             hs_c;
   logic             dir_c;
   logic             ovf_c;
   logic [WIDTH-1:0] step_a_c;
   logic [WIDTH-1:0] step_b_c;

   fib_step #(
      .WIDTH (WIDTH),
      .LIMIT (LIMIT)
   ) u_step (
      .a      (a_q),
      .b      (b_q),
      .dir    (dir_c),
      .next_a (step_a_c),
      .next_b (step_b_c),
      .ovf    (ovf_c)
   );

   // Walk backwards while descending until the seed pair, or on the BOUNCE turnaround.
   assign seed_hit_c = (a_q == SEED0) && (b_q == SEED1);
   assign hs_c       = valid_q && out_ready;
   assign dir_c      = (state_q == ST_DOWN) ? !seed_hit_c
                                            : ((mode_q == MODE_BOUNCE) && ovf_c);

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      a_d     = a_q;
      b_d     = b_q;
      valid_d = valid_q;
      done_d  = done_q;
`ifdef FIB_SEQ_IDX_EN
      idx_d   = idx_q;
`endif
      if (start) begin
         state_d = ST_UP;
         mode_d  = norm_mode(mode);
         a_d     = SEED0;
         b_d     = SEED1;
         valid_d = 1'b1;
         done_d  = 1'b0;
`ifdef FIB_SEQ_IDX_EN
         idx_d   = IDX_W'(1);
`endif
      end else if (hs_c) begin
         case (state_q)
            ST_UP: begin
               if ((mode_q == MODE_STOP) && ovf_c) begin
                  state_d = ST_DONE;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  a_d = step_a_c;
                  b_d = step_b_c;
                  if (dir_c) state_d = ST_DOWN;
`ifdef FIB_SEQ_IDX_EN
                  idx_d = dir_c ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
`endif
               end
            end
            ST_DOWN: begin
               a_d = step_a_c;
               b_d = step_b_c;
               if (!dir_c) state_d = ST_UP;
`ifdef FIB_SEQ_IDX_EN
               idx_d = dir_c ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
`endif
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_WRAP;
         a_q     <= '0;
         b_q     <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
`ifdef FIB_SEQ_IDX_EN
         idx_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         a_q     <= a_d;
         b_q     <= b_d;
         valid_q <= valid_d;
         done_q  <= done_d;
`ifdef FIB_SEQ_IDX_EN
         idx_q   <= idx_d;
`endif
      end
   end

   assign fn        = b_q;
   assign out_valid = valid_q;
   assign done      = done_q;
`ifdef FIB_SEQ_IDX_EN
   assign idx       = idx_q;
`endif

endmodule

// File: tb/tb_fib_seq_gen.sv
// Scoreboard bench for fib_seq_gen: driver queues expected terms, monitor checks each accepted one.
module tb_fib_seq_gen;

   localparam int unsigned W = 20;

   typedef struct packed {
      logic [W-1:0] fn;
      logic [7:0]   idx;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [1:0]   mode;
   logic         out_ready;
   logic         out_valid;
   logic [W-1:0] fn;
   logic         done;
`ifdef FIB_SEQ_IDX_EN
   logic [7:0]   idx;
`endif

   int checks = 0;
   int errors = 0;
   exp_t         exp_q[$];
   logic [W-1:0] act_log[$];
   exp_t         e;

   always #5 clk = ~clk;

   fib_seq_gen dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mode      (mode),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .fn        (fn),
      .done      (done)
`ifdef FIB_SEQ_IDX_EN
      ,
      .idx       (idx)
`endif
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   // Reference term F(n) for seeds 0,1, reduced mod 2**W.
   function automatic logic [W-1:0] fib(input int n);
      longint fa = 0;
      longint fb = 1;
      longint t;
      for (int i = 1; i < n; i++) begin
         t  = fa + fb;
         fa = fb;
         fb = t;
      end
      return W'(fb);
   endfunction

   task automatic push_term(input int n);
      exp_t x;
      x.fn  = fib(n);
      x.idx = 8'(n);
      exp_q.push_back(x);
   endtask

   task automatic start_run(input logic [1:0] m);
      start = 1'b1;
      mode  = m;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic accept(input int n);
      out_ready = 1'b1;
      repeat (n) @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   // Monitor: every accepted term must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         act_log.push_back(fn);
         if (exp_q.size() == 0) begin
            check("unexpected_term", 32'(fn), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("term_fn", 32'(fn), 32'(e.fn));
`ifdef FIB_SEQ_IDX_EN
            check("term_idx", 32'(idx), 32'(e.idx));
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; mode = 2'b00; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_fn", 32'(fn), 0);
      check("reset_valid", 32'(out_valid), 0);
      check("reset_done", 32'(done), 0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("idle_valid", 32'(out_valid), 0);

      // WRAP: 31 terms, last one wraps past 2**20
      act_log.delete();
      for (int n = 1; n <= 31; n++) push_term(n);
      start_run(2'b00);
      accept(31);
      check("t1_drained", 32'(exp_q.size()), 0);
      check("t1_term10", 32'(act_log[9]), 55);
      check("t1_term20", 32'(act_log[19]), 6765);
      check("t1_term30", 32'(act_log[29]), 832040);
      check("t1_term31", 32'(act_log[30]), 297693);

      // STOP: mode input changed mid-run must be ignored
      for (int n = 1; n <= 30; n++) push_term(n);
      start_run(2'b01);
      mode = 2'b00;
      out_ready = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("t2_valid", 32'(out_valid), 0);
      check("t2_done", 32'(done), 1);
      check("t2_fn_hold", 32'(fn), 832040);
      repeat (3) @(posedge clk);
      #1 out_ready = 1'b0;
      check("t2_done_sticky", 32'(done), 1);
      check("t2_valid_sticky", 32'(out_valid), 0);
      check("t2_drained", 32'(exp_q.size()), 0);

      // BOUNCE: up to the limit, down to the seeds, up again
      for (int n = 1; n <= 30; n++) push_term(n);
      for (int n = 29; n >= 1; n--) push_term(n);
      for (int n = 2; n <= 5; n++) push_term(n);
      start_run(2'b10);
      check("t3_done_cleared", 32'(done), 0);
      accept(63);
      check("t3_drained", 32'(exp_q.size()), 0);

      // Back-pressure at 55 using mode encoding 11
      for (int n = 1; n <= 11; n++) push_term(n);
      start_run(2'b11);
      accept(9);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t4_stall_fn", 32'(fn), 55);
         check("t4_stall_valid", 32'(out_valid), 1);
         @(posedge clk);
         #1;
      end
      accept(2);
      check("t4_drained", 32'(exp_q.size()), 0);

      // Restart at 6765 with ready high: start wins over the handshake
      for (int n = 1; n <= 20; n++) push_term(n);
      start_run(2'b00);
      out_ready = 1'b1;
      repeat (19) @(posedge clk);
      #1;
      for (int n = 1; n <= 3; n++) push_term(n);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("t5_fn", 32'(fn), 1);
      check("t5_done", 32'(done), 0);
`ifdef FIB_SEQ_IDX_EN
      check("t5_idx", 32'(idx), 1);
`endif
      repeat (3) @(posedge clk);
      #1 out_ready = 1'b0;
      check("t5_drained", 32'(exp_q.size()), 0);

      // Reset mid-run with start asserted
      for (int n = 1; n <= 5; n++) push_term(n);
      start_run(2'b00);
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      check("t6_fn", 32'(fn), 0);
      check("t6_valid", 32'(out_valid), 0);
      check("t6_done", 32'(done), 0);
      rst_n = 1'b1;
      start = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("t6_idle_valid", 32'(out_valid), 0);
      end
      @(posedge clk);
      #1;
      for (int n = 1; n <= 3; n++) push_term(n);
      start_run(2'b00);
      accept(3);
      check("t6_drained", 32'(exp_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
